// File: rtl/nrisc_multiciclo.sv
// rtl/nrisc_multiciclo.sv - multi-cycle nRISC core with req/ack memory handshakes
//
// Multi-cycle nRISC core: 8-bit instructions, DATA_W-bit datapath, four registers
// R0..R3, FETCH/EXEC/MEM/HALT sequencing with unbounded memory wait states.
//
// Ports:
//   clock, reset              rising-edge clock, asynchronous active-high reset
//   imem_req/addr/ack/rdata   instruction fetch handshake (addr = PC)
//   dmem_req/we/addr/wdata    data access request, held stable until dmem_ack
//   dmem_ack/rdata            data access completion and load data
//   halted                    core has executed HALT
//   retired                   16-bit wrapping retired-instruction count
module nrisc_multiciclo #(
  parameter int DATA_W = 8,
  parameter int PC_W = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic              clock,
  input  logic              reset,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_ack,
  input  logic [7:0]        imem_rdata,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              halted,
  output logic [15:0]       retired
);

  typedef enum logic [1:0] {FETCH, EXEC, MEM, HALT} state_t;

  state_t            state, nextState;
  logic [PC_W-1:0]   pc, pcNext;
  logic [7:0]        ir;
  logic [DATA_W-1:0] regs [4];
  logic [DATA_W-1:0] memAddr, memWdata;
  logic              memWe;

  logic              irWe, pcWe, regWe, memLatch, retireInc;
  logic [DATA_W-1:0] regWdata;

  // Instruction fields
  logic [2:0]        op, imm3;
  logic              f;
  logic [1:0]        ra, rb;
  logic [DATA_W-1:0] raVal, rbVal, immSext, offSext;

  assign op      = ir[7:5];
  assign f       = ir[4];
  assign ra      = ir[3:2];
  assign rb      = ir[1:0];
  assign imm3    = ir[4:2];
  assign raVal   = regs[ra];
  assign rbVal   = regs[rb];
  assign immSext = {{(DATA_W-3){imm3[2]}}, imm3};
  assign offSext = {{(DATA_W-2){ir[3]}}, ir[3:2]};

  // Gating with reset keeps the fetch request low until reset is released,
  // so the first request appears in the first cycle after deassertion.
  assign imem_req   = (state == FETCH) && !reset;
  assign imem_addr  = pc;
  assign dmem_req   = (state == MEM);
  assign dmem_we    = memWe;
  assign dmem_addr  = memAddr;
  assign dmem_wdata = memWdata;
  assign halted     = (state == HALT);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= FETCH;
    else       state <= nextState;
  end

  always_comb begin
    nextState = state;
    irWe      = 1'b0;
    pcWe      = 1'b0;
    pcNext    = pc;
    regWe     = 1'b0;
    regWdata  = '0;
    memLatch  = 1'b0;
    retireInc = 1'b0;
    case (state)
      FETCH: begin
        if (imem_ack) begin
          irWe      = 1'b1;
          nextState = EXEC;
        end
      end
      EXEC: begin
        pcWe      = 1'b1;
        pcNext    = pc + {{(PC_W-1){1'b0}}, 1'b1};
        retireInc = 1'b1;
        nextState = FETCH;
        case (op)
          3'b000: begin
            regWe    = 1'b1;
            regWdata = f ? (rbVal - raVal) : (rbVal + raVal);
          end
          3'b001: begin
            regWe    = 1'b1;
            regWdata = f ? (rbVal | raVal) : (rbVal & raVal);
          end
          3'b010: begin
            regWe    = 1'b1;
            regWdata = rbVal + immSext;
          end
          3'b011: begin
            regWe    = 1'b1;
            regWdata = immSext;
          end
          3'b100: begin
            // PC advance and retirement are deferred to the MEM acknowledge.
            memLatch  = 1'b1;
            pcWe      = 1'b0;
            retireInc = 1'b0;
            nextState = MEM;
          end
          3'b101: begin
            if (rbVal != '0)
              pcNext = pc + {{(PC_W-1){1'b0}}, 1'b1} + {{(PC_W-3){1'b0}}, imm3};
          end
          3'b110: pcNext = PC_W'(rbVal);
          default: begin
            if (!f) begin
              pcWe      = 1'b0;
              nextState = HALT;
            end
          end
        endcase
      end
      MEM: begin
        if (dmem_ack) begin
          pcWe      = 1'b1;
          pcNext    = pc + {{(PC_W-1){1'b0}}, 1'b1};
          retireInc = 1'b1;
          nextState = FETCH;
          if (!memWe) begin
            regWe    = 1'b1;
            regWdata = dmem_rdata;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc       <= RESET_PC;
      ir       <= '0;
      memAddr  <= '0;
      memWdata <= '0;
      memWe    <= 1'b0;
      retired  <= '0;
      for (int i = 0; i < 4; i++) regs[i] <= '0;
    end else begin
      if (irWe)      ir <= imem_rdata;
      if (pcWe)      pc <= pcNext;
      if (regWe)     regs[rb] <= regWdata;
      if (retireInc) retired <= retired + 16'd1;
      // Address is captured from R3 here, so a later LW into R3 cannot disturb it.
      if (memLatch) begin
        memAddr  <= regs[3] + offSext;
        memWdata <= rbVal;
        memWe    <= f;
      end
    end
  end

endmodule

// File: tb/tb_nrisc_multiciclo.sv
// tb/tb_nrisc_multiciclo.sv - directed self-checking bench for nrisc_multiciclo
module tb_nrisc_multiciclo;

  logic        clock;
  logic        reset;
  logic        imemAck;
  logic [7:0]  imemRdata;
  logic        dmemAck;
  logic [15:0] dmemRdata;

  logic        imemReq8, dmemReq8, dmemWe8, halted8;
  logic [7:0]  imemAddr8, dmemAddr8, dmemWdata8;
  logic [15:0] retired8;

  logic        imemReq16, dmemReq16, dmemWe16, halted16;
  logic [7:0]  imemAddr16;
  logic [15:0] dmemAddr16, dmemWdata16, retired16;

  int errors = 0;
  int checks = 0;

  nrisc_multiciclo #(.DATA_W(8), .PC_W(8), .RESET_PC(8'h00)) u8 (
    .clock(clock), .reset(reset),
    .imem_req(imemReq8), .imem_addr(imemAddr8), .imem_ack(imemAck), .imem_rdata(imemRdata),
    .dmem_req(dmemReq8), .dmem_we(dmemWe8), .dmem_addr(dmemAddr8), .dmem_wdata(dmemWdata8),
    .dmem_ack(dmemAck), .dmem_rdata(dmemRdata[7:0]),
    .halted(halted8), .retired(retired8)
  );

  nrisc_multiciclo #(.DATA_W(16), .PC_W(8), .RESET_PC(8'h00)) u16 (
    .clock(clock), .reset(reset),
    .imem_req(imemReq16), .imem_addr(imemAddr16), .imem_ack(imemAck), .imem_rdata(imemRdata),
    .dmem_req(dmemReq16), .dmem_we(dmemWe16), .dmem_addr(dmemAddr16), .dmem_wdata(dmemWdata16),
    .dmem_ack(dmemAck), .dmem_rdata(dmemRdata),
    .halted(halted16), .retired(retired16)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chkCtl(input string tag, input logic iReq, input logic dReq, input logic hlt,
                        input logic [15:0] ret);
    chk({tag, "_imem_req8"}, {15'd0, imemReq8}, {15'd0, iReq});
    chk({tag, "_imem_req16"}, {15'd0, imemReq16}, {15'd0, iReq});
    chk({tag, "_dmem_req8"}, {15'd0, dmemReq8}, {15'd0, dReq});
    chk({tag, "_dmem_req16"}, {15'd0, dmemReq16}, {15'd0, dReq});
    chk({tag, "_halted8"}, {15'd0, halted8}, {15'd0, hlt});
    chk({tag, "_halted16"}, {15'd0, halted16}, {15'd0, hlt});
    chk({tag, "_retired8"}, retired8, ret);
    chk({tag, "_retired16"}, retired16, ret);
  endtask

  // Presents one instruction after `waits` wait cycles, then lets EXEC complete.
  task automatic fetch(input logic [7:0] pc, input logic [7:0] instr, input int waits);
    for (int i = 0; i < waits; i++) begin
      @(negedge clock);
      chk($sformatf("fetch_wait_req_pc%0h", pc), {15'd0, imemReq8 & imemReq16}, 16'd1);
      chk($sformatf("fetch_wait_addr8_pc%0h", pc), {8'd0, imemAddr8}, {8'd0, pc});
      chk($sformatf("fetch_wait_addr16_pc%0h", pc), {8'd0, imemAddr16}, {8'd0, pc});
    end
    @(negedge clock);
    chk($sformatf("fetch_req_pc%0h", pc), {15'd0, imemReq8 & imemReq16}, 16'd1);
    chk($sformatf("fetch_addr8_pc%0h", pc), {8'd0, imemAddr8}, {8'd0, pc});
    chk($sformatf("fetch_addr16_pc%0h", pc), {8'd0, imemAddr16}, {8'd0, pc});
    imemAck   = 1'b1;
    imemRdata = instr;
    @(posedge clock);
    #1 imemAck = 1'b0;
    @(posedge clock);
    #1;
  endtask

  // Completes a pending data access; store data is only checked for stores.
  task automatic mem(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                     input logic [15:0] rdata, input int waits);
    for (int i = 0; i <= waits; i++) begin
      @(negedge clock);
      chk($sformatf("mem_req_a%0h", addr), {15'd0, dmemReq8 & dmemReq16}, 16'd1);
      chk($sformatf("mem_we8_a%0h", addr), {15'd0, dmemWe8}, {15'd0, we});
      chk($sformatf("mem_we16_a%0h", addr), {15'd0, dmemWe16}, {15'd0, we});
      chk($sformatf("mem_addr8_a%0h", addr), {8'd0, dmemAddr8}, {8'd0, addr[7:0]});
      chk($sformatf("mem_addr16_a%0h", addr), dmemAddr16, addr);
      if (we) begin
        chk($sformatf("mem_wdata8_a%0h", addr), {8'd0, dmemWdata8}, {8'd0, wdata[7:0]});
        chk($sformatf("mem_wdata16_a%0h", addr), dmemWdata16, wdata);
      end
    end
    dmemAck   = 1'b1;
    dmemRdata = rdata;
    @(posedge clock);
    #1 dmemAck = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    imemAck   = 1'b0;
    imemRdata = 8'h00;
    dmemAck   = 1'b0;
    dmemRdata = 16'h0000;
    repeat (2) @(negedge clock);
    chkCtl("reset", 1'b0, 1'b0, 1'b0, 16'd0);
    reset = 1'b0;
    #1;
    chk("post_reset_req", {15'd0, imemReq8 & imemReq16}, 16'd1);
    chk("post_reset_addr", {8'd0, imemAddr8}, 16'h0000);

    // LI R1,3 ; SW R1,+0 ; HALT
    fetch(8'h00, 8'h6D, 0);
    fetch(8'h01, 8'h91, 0);
    mem(1'b1, 16'h0000, 16'h0003, 16'h0000, 0);
    chkCtl("pre_halt", 1'b1, 1'b0, 1'b0, 16'd2);
    fetch(8'h02, 8'hE0, 0);
    chkCtl("halt", 1'b0, 1'b0, 1'b1, 16'd3);
    // Ack with no request outstanding must be ignored.
    @(negedge clock);
    imemAck   = 1'b1;
    imemRdata = 8'h65;
    @(posedge clock);
    #1 imemAck = 1'b0;
    @(negedge clock);
    chkCtl("halt_stray_ack", 1'b0, 1'b0, 1'b1, 16'd3);

    reset = 1'b1;
    #1 chkCtl("reset2", 1'b0, 1'b0, 1'b0, 16'd0);
    chk("reset2_pc", {8'd0, imemAddr8}, 16'h0000);
    @(negedge clock);
    reset = 1'b0;

    // LI R3,2 with 5 fetch wait cycles
    fetch(8'h00, 8'h6B, 5);
    chk("wait_retired", retired8, 16'd1);
    fetch(8'h01, 8'h7C, 0);                               // LI R0,-1
    fetch(8'h02, 8'h94, 0);                               // SW R0,+1
    mem(1'b1, 16'h0003, 16'hFFFF, 16'h0000, 2);
    fetch(8'h03, 8'h65, 0);                               // LI R1,1
    fetch(8'h04, 8'hA9, 0);                               // BNEZ R1,+2 taken
    fetch(8'h07, 8'h86, 0);                               // LW R2,+1
    mem(1'b0, 16'h0003, 16'h0000, 16'h005A, 1);
    fetch(8'h08, 8'h9E, 0);                               // SW R2,-1
    mem(1'b1, 16'h0001, 16'h005A, 16'h0000, 0);
    fetch(8'h09, 8'h61, 0);                               // LI R1,0
    fetch(8'h0A, 8'hA9, 0);                               // BNEZ R1,+2 not taken
    fetch(8'h0B, 8'h82, 0);                               // LW R2,+0
    mem(1'b0, 16'h0002, 16'h0000, 16'h0020, 0);
    fetch(8'h0C, 8'hC2, 0);                               // JR R2
    chk("after_jr_retired", retired8, 16'd11);

    fetch(8'h20, 8'h70, 0);                               // LI R0,-4
    fetch(8'h21, 8'h4C, 0);                               // ADDI R0,+3
    fetch(8'h22, 8'h90, 0);                               // SW R0,+0
    mem(1'b1, 16'h0002, 16'hFFFF, 16'h0000, 0);
    fetch(8'h23, 8'h65, 0);                               // LI R1,1
    fetch(8'h24, 8'h04, 0);                               // ADD R0=R0+R1 wraps to 0
    fetch(8'h25, 8'h90, 0);
    mem(1'b1, 16'h0002, 16'h0000, 16'h0000, 0);
    fetch(8'h26, 8'h14, 0);                               // SUB R0=R0-R1 wraps to all-ones
    fetch(8'h27, 8'h90, 0);
    mem(1'b1, 16'h0002, 16'hFFFF, 16'h0000, 0);
    fetch(8'h28, 8'h21, 0);                               // AND R1=R1&R0
    fetch(8'h29, 8'h36, 0);                               // OR R2=R2|R1
    fetch(8'h2A, 8'h96, 0);                               // SW R2,+1
    mem(1'b1, 16'h0003, 16'h0021, 16'h0000, 0);
    fetch(8'h2B, 8'h83, 0);                               // LW R3,+0
    mem(1'b0, 16'h0002, 16'h0000, 16'h0010, 0);
    fetch(8'h2C, 8'h93, 0);                               // SW R3,+0 uses new R3
    mem(1'b1, 16'h0010, 16'h0010, 16'h0000, 0);
    chkCtl("pre_abort", 1'b1, 1'b0, 1'b0, 16'd24);

    // LW R0,+0 aborted by reset while the ack is pending
    fetch(8'h2D, 8'h80, 0);
    @(negedge clock);
    chk("abort_req_before", {15'd0, dmemReq8 & dmemReq16}, 16'd1);
    dmemAck   = 1'b1;
    dmemRdata = 16'h00AA;
    #1 reset = 1'b1;
    #1;
    chkCtl("abort", 1'b0, 1'b0, 1'b0, 16'd0);
    chk("abort_pc", {8'd0, imemAddr8}, 16'h0000);
    @(posedge clock);
    #1 dmemAck = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("abort_release_req", {15'd0, imemReq8 & imemReq16}, 16'd1);
    fetch(8'h00, 8'h90, 0);                               // SW R0,+0: R0 and R3 are clear
    mem(1'b1, 16'h0000, 16'h0000, 16'h0000, 0);
    chk("abort_retired", retired16, 16'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
